cca_box_scheduler: RTL and testbench
====================================

// Module: cca_box_scheduler
// PURPOSE
//  Frame-level sequencer behind the run-length CCA labeller. Collects the per-frame
//  bounding-box stream (box valid pulse + packed box) between frame markers into a
//  register buffer, then drains it to a downstream consumer over a valid/ready handshake.
//  Frames arriving while a drain is in progress are rejected and flagged, never merged.
// PARAMETERS
//  IMWIDTH    640  image width; X_BIT = $clog2(IMWIDTH)
//  IMHEIGHT   480  image height; Y_BIT = $clog2(IMHEIGHT)
//  DATA_BIT   2*(X_BIT+Y_BIT)  packed box width, {xmin,xmax,ymin,ymax}, MSB first
//  MAX_BOXES  16   buffer depth (power of 2, >=2); CNT_BIT = $clog2(MAX_BOXES)+1
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous active-high reset
//  frame_start  in   1         one-cycle pulse, first pixel of frame
//  frame_end    in   1         one-cycle pulse, after last labeller output of frame
//  box_valid    in   1         labeller box strobe
//  box_in       in   DATA_BIT  packed box
//  min_dim      in   X_BIT     min width/height (used only with CCA_BOX_MINSIZE_EN)
//  out_valid    out  1         box available to consumer
//  out_ready    in   1         consumer accepts box
//  out_box      out  DATA_BIT  box being offered
//  out_last     out  1         offered box is last of frame
//  box_count    out  CNT_BIT   boxes stored for current/last frame
//  frame_done   out  1         one-cycle pulse when frame fully drained (or empty)
//  overflow     out  1         sticky: >=1 box dropped, buffer full
//  frame_skip   out  1         one-cycle pulse: frame_start rejected (not IDLE)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; wr/rd pointers 0; buffer contents don't-care.
//  FSM IDLE -> COLLECT on frame_start: box_count<=0, overflow<=0.
//  COLLECT: box_valid writes box_in at wr_ptr next edge, box_count++; when
//   box_count==MAX_BOXES box dropped, overflow<=1, count saturates.
//  COLLECT -> DRAIN on frame_end if box_count>0 (incl. box accepted same cycle);
//   -> DONE if 0. box_valid and frame_end same cycle: box stored, then DRAIN.
//  DRAIN: out_valid=1, out_box=buf[rd_ptr] (rd_ptr registered), out_last=(rd_ptr==box_count-1);
//   out_valid&out_ready advances rd_ptr; out_box/out_last stable while out_valid&!out_ready.
//   Handshake with out_last -> DONE. First box offered the cycle after frame_end.
//  DONE: frame_done=1 for one cycle, rd_ptr<=0 -> IDLE. box_count held until next accepted frame.
//  frame_start in COLLECT/DRAIN/DONE: ignored, frame_skip pulses; frame_end outside COLLECT ignored.
//  box_valid outside COLLECT ignored (not counted, no overflow).
//  frame_start and frame_end same cycle in IDLE: start taken, end ignored.
//  rst mid-frame or mid-drain: immediate return to IDLE, out_valid low next cycle, no frame_done.
// CONFIGURATION
//  CCA_BOX_MINSIZE_EN defined: in COLLECT, box with (xmax-xmin+1)<min_dim or
//   (ymax-ymin+1)<min_dim (ymax-ymin zero-extended to X_BIT) discarded: not stored,
//   not counted, no overflow. Not defined: min_dim unused, every box stored.
// STRUCTURE
//  Shared package cca_pkg: X_BIT/Y_BIT/DATA_BIT derivation, box field slice localparams,
//   FSM state encoding (IDLE, COLLECT, DRAIN, DONE).
//  Sub-module cca_box_buf: MAX_BOXES x DATA_BIT register file, 1 write, async-index read.
// TESTING
//  1 start; 3 boxes {10,20,5,9},{30,40,1,2},{0,639,0,479}; end; ready=1 -> 3 boxes in order,
//    out_last on 3rd, frame_done 1 cycle after, box_count=3.
//  2 start; 20 boxes (MAX_BOXES=16); end -> boxes 0..15 out, overflow=1, count=16.
//  3 start, end, no boxes -> frame_done next-next cycle, out_valid never high, count=0.
//  4 out_ready low 5 cycles in DRAIN -> out_box stable; frame_start then -> frame_skip, drain continues.
//  5 box_valid with frame_end same cycle -> box stored, delivered last; rst during DRAIN -> IDLE, no frame_done.
//  6 CCA_BOX_MINSIZE_EN, min_dim=4: boxes widths 3 and 4 (height 10) -> only width-4 box stored, count=1.

Source files
------------

// File: rtl/cca_pkg.sv
// ---------------------------------------------------------------------------
// cca_pkg
// Definitions shared by the CCA box scheduler and its box buffer:
//   - default image geometry and buffer depth
//   - helpers that derive the coordinate widths and the packed box width
//   - bit offsets of the fields inside a packed box {xmin,xmax,ymin,ymax}
//   - the scheduler FSM state encoding
// ---------------------------------------------------------------------------
package cca_pkg;

    localparam int IMWIDTH_DEF   = 640;
    localparam int IMHEIGHT_DEF  = 480;
    localparam int MAX_BOXES_DEF = 16;

    // Coordinate widths and packed box width for a given image geometry.
    function automatic int x_bit_of(input int imwidth);
        return $clog2(imwidth);
    endfunction

    function automatic int y_bit_of(input int imheight);
        return $clog2(imheight);
    endfunction

    function automatic int data_bit_of(input int imwidth, input int imheight);
        return 2 * ($clog2(imwidth) + $clog2(imheight));
    endfunction

    // Field LSB positions; ymax occupies the bottom of the word.
    function automatic int ymax_lsb_of(input int imheight);
        return 0;
    endfunction

    function automatic int ymin_lsb_of(input int imheight);
        return $clog2(imheight);
    endfunction

    function automatic int xmax_lsb_of(input int imheight);
        return 2 * $clog2(imheight);
    endfunction

    function automatic int xmin_lsb_of(input int imwidth, input int imheight);
        return 2 * $clog2(imheight) + $clog2(imwidth);
    endfunction

    localparam int X_BIT_DEF    = 10;
    localparam int Y_BIT_DEF    = 9;
    localparam int DATA_BIT_DEF = 2 * (X_BIT_DEF + Y_BIT_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/cca_box_buf.sv
// ---------------------------------------------------------------------------
// cca_box_buf
// DEPTH x WIDTH register file holding the boxes of one frame.
// One synchronous write port, one asynchronous (index-driven) read port.
// Contents are not reset: the scheduler never reads an entry it did not
// write during the current frame.
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_idx   write index
//   wr_data  word to write
//   rd_idx   read index
//   rd_data  word at rd_idx (combinational)
// ---------------------------------------------------------------------------
module cca_box_buf #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 38,
    parameter int IDX_BIT = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [IDX_BIT-1:0] wr_idx,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [IDX_BIT-1:0] rd_idx,
    output logic [WIDTH-1:0]   rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cca_box_scheduler.sv
// ---------------------------------------------------------------------------
// cca_box_scheduler
// Frame-level sequencer behind the run-length CCA labeller. Boxes strobed in
// between frame_start and frame_end are stored in a register buffer, then
// offered one by one over a valid/ready handshake. A frame_start seen while a
// frame is still being collected or drained is rejected (frame_skip pulse).
//
// Optional feature (compile-time macro CCA_BOX_MINSIZE_EN): boxes narrower or
// shorter than min_dim are discarded during collection. Without the macro
// every box is stored and min_dim is ignored.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   frame_start  one-cycle pulse at first pixel of a frame
//   frame_end    one-cycle pulse after the last labeller output of a frame
//   box_valid    box strobe, box_in packed {xmin,xmax,ymin,ymax}
//   min_dim      minimum box width/height (CCA_BOX_MINSIZE_EN only)
//   out_valid / out_ready / out_box / out_last   downstream handshake
//   box_count    boxes stored for the current / last accepted frame
//   frame_done   one-cycle pulse when a frame has been fully drained
//   overflow     sticky per frame: at least one box dropped on a full buffer
//   frame_skip   one-cycle pulse, cycle after a rejected frame_start
// ---------------------------------------------------------------------------
module cca_box_scheduler
    import cca_pkg::*;
#(
    parameter int IMWIDTH   = IMWIDTH_DEF,
    parameter int IMHEIGHT  = IMHEIGHT_DEF,
    parameter int MAX_BOXES = MAX_BOXES_DEF,
    parameter int X_BIT     = x_bit_of(IMWIDTH),
    parameter int Y_BIT     = y_bit_of(IMHEIGHT),
    parameter int DATA_BIT  = data_bit_of(IMWIDTH, IMHEIGHT),
    parameter int CNT_BIT   = $clog2(MAX_BOXES) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                frame_end,
    input  logic                box_valid,
    input  logic [DATA_BIT-1:0] box_in,
    input  logic [X_BIT-1:0]    min_dim,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_BIT-1:0] out_box,
    output logic                out_last,
    output logic [CNT_BIT-1:0]  box_count,
    output logic                frame_done,
    output logic                overflow,
    output logic                frame_skip
);

    localparam int IDX_BIT = CNT_BIT - 1;

    state_t               state, state_nxt;
    logic [IDX_BIT-1:0]   rd_ptr;
    logic [DATA_BIT-1:0]  rd_data;
    logic                 size_ok;
    logic                 box_keep;
    logic                 buf_full;
    logic                 wr_en;
    logic                 handshake;
    logic                 at_last;

`ifdef CCA_BOX_MINSIZE_EN
    localparam int XMIN_LSB = xmin_lsb_of(IMWIDTH, IMHEIGHT);
    localparam int XMAX_LSB = xmax_lsb_of(IMHEIGHT);
    localparam int YMIN_LSB = ymin_lsb_of(IMHEIGHT);
    localparam int YMAX_LSB = ymax_lsb_of(IMHEIGHT);

    logic [X_BIT-1:0] xmin, xmax;
    logic [Y_BIT-1:0] ymin, ymax;
    logic [Y_BIT-1:0] dy;
    logic [X_BIT:0]   box_w, box_h;

    assign xmin = box_in[XMIN_LSB +: X_BIT];
    assign xmax = box_in[XMAX_LSB +: X_BIT];
    assign ymin = box_in[YMIN_LSB +: Y_BIT];
    assign ymax = box_in[YMAX_LSB +: Y_BIT];
    assign dy   = ymax - ymin;

    // One extra bit so a full-width box (extent == IMWIDTH) cannot wrap to 0.
    assign box_w   = {1'b0, xmax} - {1'b0, xmin} + (X_BIT+1)'(1);
    assign box_h   = (X_BIT+1)'(dy) + (X_BIT+1)'(1);
    assign size_ok = (box_w >= {1'b0, min_dim}) && (box_h >= {1'b0, min_dim});
`else
    logic unused_min_dim;
    assign unused_min_dim = ^min_dim;
    assign size_ok        = 1'b1;
`endif

    assign box_keep  = (state == COLLECT) && box_valid && size_ok;
    assign buf_full  = (box_count == CNT_BIT'(MAX_BOXES));
    assign wr_en     = box_keep && !buf_full;
    assign handshake = (state == DRAIN) && out_ready;
    assign at_last   = ({1'b0, rd_ptr} == (box_count - CNT_BIT'(1)));

    // box_count doubles as the write pointer: it is below MAX_BOXES whenever wr_en is high.
    cca_box_buf #(
        .DEPTH   (MAX_BOXES),
        .WIDTH   (DATA_BIT),
        .IDX_BIT (IDX_BIT)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (box_count[IDX_BIT-1:0]),
        .wr_data (box_in),
        .rd_idx  (rd_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = COLLECT;
            // A box accepted in the frame_end cycle counts toward a non-empty frame.
            COLLECT: if (frame_end) state_nxt = ((box_count != '0) || wr_en) ? DRAIN : DONE;
            DRAIN:   if (handshake && at_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            box_count  <= '0;
            overflow   <= 1'b0;
            frame_skip <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_skip <= frame_start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        box_count <= '0;
                        overflow  <= 1'b0;
                        rd_ptr    <= '0;
                    end
                end
                COLLECT: begin
                    if (wr_en)               box_count <= box_count + CNT_BIT'(1);
                    if (box_keep && buf_full) overflow  <= 1'b1;
                end
                DRAIN: begin
                    if (handshake && !at_last) rd_ptr <= rd_ptr + IDX_BIT'(1);
                end
                DONE: begin
                    rd_ptr <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced to zero outside DRAIN so nothing stale leaks to the consumer.
    assign out_valid  = (state == DRAIN);
    assign out_box    = out_valid ? rd_data : '0;
    assign out_last   = out_valid && at_last;
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_cca_box_scheduler.sv
module tb_cca_box_scheduler;

    typedef logic [37:0] box_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start, frame_end, box_valid;
    box_t       box_in;
    logic [9:0] min_dim;
    logic       out_valid, out_ready, out_last;
    box_t       out_box;
    logic [4:0] box_count;
    logic       frame_done, overflow, frame_skip;

    int total = 0;
    int bad   = 0;

    box_t cap_q[$];
    int   cap_last_pos, cap_last_step, cap_done_step;
    bit   cap_done;

    always #5 clk = ~clk;

    cca_box_scheduler dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .box_valid(box_valid), .box_in(box_in), .min_dim(min_dim),
        .out_valid(out_valid), .out_ready(out_ready), .out_box(out_box),
        .out_last(out_last), .box_count(box_count), .frame_done(frame_done),
        .overflow(overflow), .frame_skip(frame_skip)
    );

    function automatic box_t pack(input int xmin, input int xmax, input int ymin, input int ymax);
        return {10'(xmin), 10'(xmax), 9'(ymin), 9'(ymax)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0; box_valid = 1'b0;
        box_in = '0; out_ready = 1'b0; min_dim = 10'd4;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic send_box(input box_t b);
        box_valid = 1'b1; box_in = b; tick(); box_valid = 1'b0;
    endtask

    task automatic end_frame();
        frame_end = 1'b1; tick(); frame_end = 1'b0;
    endtask

    // Accepts every offered box until frame_done or the cycle budget runs out.
    task automatic drain_capture(input int budget);
        cap_q.delete();
        cap_last_pos = -1; cap_last_step = -1; cap_done_step = -1; cap_done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (frame_done) begin
                cap_done = 1'b1; cap_done_step = i;
                break;
            end
            if (out_valid) begin
                if (out_last) begin
                    cap_last_pos = cap_q.size(); cap_last_step = i;
                end
                cap_q.push_back(out_box);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_box !== '0)       begin bad++; $display("FAIL reset_out_box got=%h exp=0", out_box); end
        total++; if (out_last !== 1'b0)    begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        total++; if (box_count !== 5'd0)   begin bad++; $display("FAIL reset_box_count got=%0d exp=0", box_count); end
        total++; if (frame_done !== 1'b0)  begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (frame_skip !== 1'b0)  begin bad++; $display("FAIL reset_frame_skip got=%b exp=0", frame_skip); end
    endtask

    task automatic test_basic();
        box_t exp_b[3];
        exp_b[0] = pack(10, 20, 5, 9);
        exp_b[1] = pack(30, 40, 1, 2);
        exp_b[2] = pack(0, 639, 0, 479);
        start_frame();
        total++; if (frame_skip !== 1'b0) begin bad++; $display("FAIL basic_no_skip got=%b exp=0", frame_skip); end
        for (int i = 0; i < 3; i++) send_box(exp_b[i]);
        end_frame();
        total++; if (out_valid !== 1'b1)  begin bad++; $display("FAIL basic_first_valid got=%b exp=1", out_valid); end
        total++; if (out_box !== exp_b[0]) begin bad++; $display("FAIL basic_first_box got=%h exp=%h", out_box, exp_b[0]); end
        drain_capture(20);
        total++; if (cap_q.size() != 3) begin bad++; $display("FAIL basic_num_boxes got=%0d exp=3", cap_q.size()); end
        for (int i = 0; i < 3 && i < cap_q.size(); i++) begin
            total++; if (cap_q[i] !== exp_b[i]) begin bad++; $display("FAIL basic_box%0d got=%h exp=%h", i, cap_q[i], exp_b[i]); end
        end
        total++; if (cap_last_pos != 2) begin bad++; $display("FAIL basic_last_pos got=%0d exp=2", cap_last_pos); end
        total++; if (!cap_done) begin bad++; $display("FAIL basic_done_timeout got=%0d exp=1", cap_done); end
        total++; if (cap_done_step != cap_last_step + 1) begin bad++; $display("FAIL basic_done_latency got=%0d exp=%0d", cap_done_step, cap_last_step + 1); end
        total++; if (box_count !== 5'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", box_count); end
        tick();
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL basic_done_one_cycle got=%b exp=0", frame_done); end
        // Box strobe in IDLE must not be counted.
        send_box(pack(1, 2, 3, 4));
        total++; if (box_count !== 5'd3) begin bad++; $display("FAIL idle_box_ignored got=%0d exp=3", box_count); end
    endtask

    task automatic test_overflow();
        start_frame();
        for (int i = 0; i < 20; i++) send_box(pack(i, i + 5, i, i + 3));
        end_frame();
        total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (box_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", box_count); end
        drain_capture(40);
        total++; if (cap_q.size() != 16) begin bad++; $display("FAIL ovf_num_boxes got=%0d exp=16", cap_q.size()); end
        for (int i = 0; i < 16 && i < cap_q.size(); i++) begin
            total++; if (cap_q[i] !== pack(i, i + 5, i, i + 3)) begin bad++; $display("FAIL ovf_box%0d got=%h exp=%h", i, cap_q[i], pack(i, i + 5, i, i + 3)); end
        end
        total++; if (cap_last_pos != 15) begin bad++; $display("FAIL ovf_last_pos got=%0d exp=15", cap_last_pos); end
        total++; if (!cap_done) begin bad++; $display("FAIL ovf_done_timeout got=%0d exp=1", cap_done); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        tick();
    endtask

    task automatic test_empty();
        start_frame();
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL empty_ovf_cleared got=%b exp=0", overflow); end
        end_frame();
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL empty_done got=%b exp=1", frame_done); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL empty_valid got=%b exp=0", out_valid); end
        total++; if (box_count !== 5'd0)  begin bad++; $display("FAIL empty_count got=%0d exp=0", box_count); end
        tick();
        total++; if (frame_done !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL empty_after got=%b%b exp=00", frame_done, out_valid); end
    endtask

    task automatic test_stall();
        box_t p, q;
        p = pack(100, 150, 20, 60);
        q = pack(200, 201, 300, 301);
        start_frame(); send_box(p); send_box(q); end_frame();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1 || out_box !== p || out_last !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d got=%b/%h/%b exp=1/%h/0", i, out_valid, out_box, out_last, p);
            end
            tick();
        end
        start_frame();
        total++; if (frame_skip !== 1'b1) begin bad++; $display("FAIL stall_skip got=%b exp=1", frame_skip); end
        total++; if (out_valid !== 1'b1 || out_box !== p) begin bad++; $display("FAIL stall_drain_kept got=%b/%h exp=1/%h", out_valid, out_box, p); end
        tick();
        total++; if (frame_skip !== 1'b0) begin bad++; $display("FAIL stall_skip_pulse got=%b exp=0", frame_skip); end
        drain_capture(20);
        total++; if (cap_q.size() != 2) begin bad++; $display("FAIL stall_num_boxes got=%0d exp=2", cap_q.size()); end
        if (cap_q.size() == 2) begin
            total++; if (cap_q[0] !== p || cap_q[1] !== q) begin bad++; $display("FAIL stall_boxes got=%h,%h exp=%h,%h", cap_q[0], cap_q[1], p, q); end
        end
        total++; if (!cap_done) begin bad++; $display("FAIL stall_done_timeout got=%0d exp=1", cap_done); end
        tick();
    endtask

    task automatic test_end_with_box();
        box_t x, y;
        bit   saw_done;
        x = pack(7, 8, 9, 10);
        y = pack(50, 60, 70, 80);
        start_frame(); send_box(x);
        box_valid = 1'b1; box_in = y; frame_end = 1'b1; tick();
        box_valid = 1'b0; frame_end = 1'b0;
        total++; if (out_valid !== 1'b1 || out_box !== x) begin bad++; $display("FAIL same_cycle_first got=%b/%h exp=1/%h", out_valid, out_box, x); end
        drain_capture(20);
        total++; if (cap_q.size() != 2) begin bad++; $display("FAIL same_cycle_num got=%0d exp=2", cap_q.size()); end
        if (cap_q.size() == 2) begin
            total++; if (cap_q[1] !== y) begin bad++; $display("FAIL same_cycle_last_box got=%h exp=%h", cap_q[1], y); end
        end
        total++; if (cap_last_pos != 1) begin bad++; $display("FAIL same_cycle_last_pos got=%0d exp=1", cap_last_pos); end
        total++; if (box_count !== 5'd2) begin bad++; $display("FAIL same_cycle_count got=%0d exp=2", box_count); end
        tick();
        // Reset in the middle of a drain.
        start_frame(); send_box(x); send_box(y); end_frame();
        out_ready = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_drain_valid got=%b exp=0", out_valid); end
        total++; if (box_count !== 5'd0) begin bad++; $display("FAIL rst_drain_count got=%0d exp=0", box_count); end
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (frame_done === 1'b1 || out_valid === 1'b1) saw_done = 1'b1;
            tick();
        end
        total++; if (saw_done) begin bad++; $display("FAIL rst_drain_quiet got=%b exp=0", saw_done); end
    endtask

    task automatic test_start_end_same();
        box_t z;
        z = pack(3, 4, 5, 6);
        frame_start = 1'b1; frame_end = 1'b1; tick();
        frame_start = 1'b0; frame_end = 1'b0;
        total++; if (frame_done !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL start_end_idle got=%b%b exp=00", frame_done, out_valid); end
        send_box(z); end_frame();
        total++; if (out_box !== z || out_last !== 1'b1) begin bad++; $display("FAIL start_end_box got=%h/%b exp=%h/1", out_box, out_last, z); end
        drain_capture(10);
        total++; if (!cap_done || cap_q.size() != 1) begin bad++; $display("FAIL start_end_drain got=%0d/%0d exp=1/1", cap_done, cap_q.size()); end
        tick();
    endtask

    task automatic test_minsize();
        box_t narrow, wide;
        narrow = pack(10, 12, 0, 9);
        wide   = pack(20, 23, 0, 9);
        min_dim = 10'd4;
        start_frame(); send_box(narrow); send_box(wide); end_frame();
`ifdef CCA_BOX_MINSIZE_EN
        total++; if (box_count !== 5'd1) begin bad++; $display("FAIL minsize_count got=%0d exp=1", box_count); end
        total++; if (out_box !== wide || out_last !== 1'b1) begin bad++; $display("FAIL minsize_box got=%h/%b exp=%h/1", out_box, out_last, wide); end
`else
        total++; if (box_count !== 5'd2) begin bad++; $display("FAIL minsize_off_count got=%0d exp=2", box_count); end
        total++; if (out_box !== narrow || out_last !== 1'b0) begin bad++; $display("FAIL minsize_off_box got=%h/%b exp=%h/0", out_box, out_last, narrow); end
`endif
        drain_capture(10);
        total++; if (!cap_done) begin bad++; $display("FAIL minsize_done_timeout got=%0d exp=1", cap_done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_empty();
        test_stall();
        test_end_with_box();
        test_start_end_same();
        test_minsize();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
